// File: rtl/rsv_imem_resp.sv
// rsv_imem_resp: instruction memory responder.
// Fixed-latency fetch reads plus a side program-load port.
module rsv_imem_resp #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned RD_LATENCY  = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_mem_req_i,
  input  logic [31:0] fetch_mem_addr_i,
  output logic [31:0] mem_rd_inst_o,
  output logic        mem_rd_valid_o,
  output logic        mem_rd_err_o,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_data_i,
  output logic        load_err_o
);

  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam int LAT = int'(RD_LATENCY);

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } slot_t;

  logic [31:0] mem [DEPTH_WORDS];
  slot_t       pipe [LAT];

  logic [31:0] f_off;
  logic [31:0] l_off;
  logic        f_bad;
  logic        l_bad;
  logic [AW-1:0] f_idx;
  logic [AW-1:0] l_idx;

  // Address decode: offset from base, then alignment and range.
  always_comb begin
    f_off = fetch_mem_addr_i - BASE_ADDR;
    l_off = load_addr_i - BASE_ADDR;
    f_bad = (fetch_mem_addr_i < BASE_ADDR)
          | (f_off[31:AW+2] != '0)
          | (f_off[1:0] != 2'b00);
    l_bad = (load_addr_i < BASE_ADDR)
          | (l_off[31:AW+2] != '0)
          | (l_off[1:0] != 2'b00);
    f_idx = f_off[AW+1:2];
    l_idx = l_off[AW+1:2];
  end

  // Program-load write; contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && load_we_i && !l_bad) begin
      mem[l_idx] <= load_data_i;
    end
  end

  // One-cycle pulse for a dropped load write.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_err_o <= 1'b0;
    end else begin
      load_err_o <= load_we_i & l_bad;
    end
  end

  // Read pipeline: array read in stage 1, data held when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < LAT; k++) begin
        pipe[k].valid <= 1'b0;
        pipe[k].err   <= 1'b0;
        pipe[k].data  <= NOP_INST;
      end
    end else begin
      pipe[0].valid <= fetch_mem_req_i;
      pipe[0].err   <= fetch_mem_req_i & f_bad;
      if (fetch_mem_req_i) begin
        pipe[0].data <= f_bad ? NOP_INST : mem[f_idx];
      end
      for (int k = 1; k < LAT; k++) begin
        pipe[k].valid <= pipe[k-1].valid;
        pipe[k].err   <= pipe[k-1].err;
        if (pipe[k-1].valid) begin
          pipe[k].data <= pipe[k-1].data;
        end
      end
    end
  end

  assign mem_rd_valid_o = pipe[LAT-1].valid;
  assign mem_rd_err_o   = pipe[LAT-1].err;
  assign mem_rd_inst_o  = pipe[LAT-1].data;

endmodule

// File: tb/tb_rsv_imem_resp.sv
// tb_rsv_imem_resp: three responder configurations on shared stimulus.
// Directed table, hand sequences and random traffic vs. a cycle model.
module tb_rsv_imem_resp;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int HN = 4096;

  logic clk = 1'b0;
  logic reset;
  logic req;
  logic we;
  logic [31:0] addr;
  logic [31:0] laddr;
  logic [31:0] ldata;

  logic [2:0]       o_valid;
  logic [2:0]       o_err;
  logic [2:0]       o_lerr;
  logic [2:0][31:0] o_inst;

  always #5 clk = ~clk;

  rsv_imem_resp #(
    .DEPTH_WORDS(1024), .RD_LATENCY(1),
    .BASE_ADDR(32'h0000_0000), .NOP_INST(NOP)
  ) u0 (
    .clk(clk), .reset(reset),
    .fetch_mem_req_i(req), .fetch_mem_addr_i(addr),
    .mem_rd_inst_o(o_inst[0]), .mem_rd_valid_o(o_valid[0]),
    .mem_rd_err_o(o_err[0]),
    .load_we_i(we), .load_addr_i(laddr), .load_data_i(ldata),
    .load_err_o(o_lerr[0])
  );

  rsv_imem_resp #(
    .DEPTH_WORDS(1024), .RD_LATENCY(3),
    .BASE_ADDR(32'h0000_0000), .NOP_INST(NOP)
  ) u1 (
    .clk(clk), .reset(reset),
    .fetch_mem_req_i(req), .fetch_mem_addr_i(addr),
    .mem_rd_inst_o(o_inst[1]), .mem_rd_valid_o(o_valid[1]),
    .mem_rd_err_o(o_err[1]),
    .load_we_i(we), .load_addr_i(laddr), .load_data_i(ldata),
    .load_err_o(o_lerr[1])
  );

  rsv_imem_resp #(
    .DEPTH_WORDS(16), .RD_LATENCY(2),
    .BASE_ADDR(32'h8000_0000), .NOP_INST(NOP)
  ) u2 (
    .clk(clk), .reset(reset),
    .fetch_mem_req_i(req), .fetch_mem_addr_i(addr),
    .mem_rd_inst_o(o_inst[2]), .mem_rd_valid_o(o_valid[2]),
    .mem_rd_err_o(o_err[2]),
    .load_we_i(we), .load_addr_i(laddr), .load_data_i(ldata),
    .load_err_o(o_lerr[2])
  );

  int checks = 0;
  int failures = 0;

  int     lat   [3] = '{1, 3, 2};
  longint base  [3] = '{64'h0, 64'h0, 64'h8000_0000};
  longint depth [3] = '{1024, 1024, 16};

  logic [31:0] mmem [longint];
  logic        hv [3][HN];
  logic        he [3][HN];
  logic        hk [3][HN];
  logic [31:0] hd [3][HN];
  logic [31:0] last_inst [3];
  logic        last_known [3];
  logic        exp_lerr [3];
  int          edge_n = 0;

  typedef struct {
    bit          rst;
    bit          req;
    logic [31:0] addr;
    bit          we;
    logic [31:0] laddr;
    logic [31:0] ldata;
    bit          ev;
    bit          ee;
    logic [31:0] ei;
    bit          el;
  } vec_t;

  vec_t tbl [12];

  function automatic bit legal(int i, logic [31:0] a);
    longint x;
    x = longint'(a);
    return (a[1:0] == 2'b00) && (x >= base[i]) &&
           (x < base[i] + 4 * depth[i]);
  endfunction

  function automatic longint key(int i, logic [31:0] a);
    return (longint'(i) << 33) | longint'(a);
  endfunction

  function automatic logic [31:0] pre(int i);
    case (i)
      0:       return 32'h0050_0093;
      1:       return 32'h0010_0113;
      3:       return 32'hAAAA_AAAA;
      default: return 32'h1000_0000 + 32'(i);
    endcase
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r <= 3) return 32'(4 * $urandom_range(0, 15));
    if (r <= 6) return 32'h8000_0000 + 32'(4 * $urandom_range(0, 15));
    if (r == 7) return 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
    if (r == 8) return $urandom;
    case ($urandom_range(0, 2))
      0:       return 32'h0000_1000;
      1:       return 32'h8000_0040;
      default: return 32'h7FFF_FFFC;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    int e;
    e = edge_n;
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        for (int n = e - lat[i] + 1; n <= e; n++) begin
          if (n >= 0) hv[i][n] = 1'b0;
        end
        last_inst[i]  = NOP;
        last_known[i] = 1'b1;
        exp_lerr[i]   = 1'b0;
      end else begin
        hv[i][e] = req;
        he[i][e] = 1'b0;
        hk[i][e] = 1'b1;
        hd[i][e] = NOP;
        if (req) begin
          if (legal(i, addr)) begin
            if (mmem.exists(key(i, addr))) hd[i][e] = mmem[key(i, addr)];
            else hk[i][e] = 1'b0;
          end else begin
            he[i][e] = 1'b1;
          end
        end
        exp_lerr[i] = we && !legal(i, laddr);
        if (we && legal(i, laddr)) mmem[key(i, laddr)] = ldata;
      end
    end
  endtask

  task automatic check_outputs();
    int n;
    for (int i = 0; i < 3; i++) begin
      n = edge_n - lat[i] + 1;
      if (n >= 0 && hv[i][n]) begin
        chk($sformatf("u%0d_valid_e%0d", i, edge_n), 32'(o_valid[i]), 32'd1);
        chk($sformatf("u%0d_err_e%0d", i, edge_n), 32'(o_err[i]), 32'(he[i][n]));
        if (hk[i][n]) chk($sformatf("u%0d_inst_e%0d", i, edge_n), o_inst[i], hd[i][n]);
        last_inst[i]  = hd[i][n];
        last_known[i] = hk[i][n];
      end else begin
        chk($sformatf("u%0d_valid_e%0d", i, edge_n), 32'(o_valid[i]), 32'd0);
        chk($sformatf("u%0d_err_e%0d", i, edge_n), 32'(o_err[i]), 32'd0);
        if (last_known[i]) begin
          chk($sformatf("u%0d_hold_e%0d", i, edge_n), o_inst[i], last_inst[i]);
        end
      end
      chk($sformatf("u%0d_lerr_e%0d", i, edge_n), 32'(o_lerr[i]), 32'(exp_lerr[i]));
    end
  endtask

  task automatic step(input bit r, input bit q, input logic [31:0] a,
                      input bit w, input logic [31:0] la, input logic [31:0] ld);
    reset = r;
    req   = q;
    addr  = a;
    we    = w;
    laddr = la;
    ldata = ld;
    @(posedge clk);
    if (edge_n >= HN) begin
      $display("FAIL history_overflow got=%0d exp<%0d", edge_n, HN);
      $fatal(1);
    end
    model_edge();
    #1;
    check_outputs();
    edge_n++;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step(0, 0, 32'h0, 0, 32'h0, 32'h0);
  endtask

  logic [31:0] bw [5];
  int cnt;

  initial begin
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < HN; n++) begin
        hv[i][n] = 1'b0;
        he[i][n] = 1'b0;
        hk[i][n] = 1'b0;
        hd[i][n] = NOP;
      end
      last_inst[i]  = NOP;
      last_known[i] = 1'b0;
      exp_lerr[i]   = 1'b0;
    end

    tbl[0]  = '{0, 1, 32'h0000_0000, 0, 0, 0, 1, 0, 32'h0050_0093, 0};
    tbl[1]  = '{0, 1, 32'h0000_0004, 0, 0, 0, 1, 0, 32'h0010_0113, 0};
    tbl[2]  = '{0, 0, 32'h0000_0000, 0, 0, 0, 0, 0, 32'h0010_0113, 0};
    tbl[3]  = '{0, 1, 32'h0000_0002, 0, 0, 0, 1, 1, NOP, 0};
    tbl[4]  = '{0, 1, 32'h0000_1000, 0, 0, 0, 1, 1, NOP, 0};
    tbl[5]  = '{0, 0, 32'h0000_0000, 1, 32'h0000_1000, 32'hDEAD_BEEF,
                0, 0, NOP, 1};
    tbl[6]  = '{0, 1, 32'h0000_000C, 1, 32'h0000_000C, 32'hBBBB_BBBB,
                1, 0, 32'hAAAA_AAAA, 0};
    tbl[7]  = '{0, 1, 32'h0000_000C, 0, 0, 0, 1, 0, 32'hBBBB_BBBB, 0};
    tbl[8]  = '{0, 1, 32'h8000_0004, 0, 0, 0, 1, 1, NOP, 0};
    tbl[9]  = '{0, 1, 32'h7FFF_FFFC, 0, 0, 0, 1, 1, NOP, 0};
    tbl[10] = '{0, 1, 32'h0000_0010, 0, 0, 0, 1, 0, 32'h1000_0004, 0};
    tbl[11] = '{0, 1, 32'h0000_0000, 0, 0, 0, 1, 0, 32'h0050_0093, 0};

    step(1, 0, 32'h0, 0, 32'h0, 32'h0);
    step(1, 1, 32'h0, 1, 32'h0, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_inst_u%0d", i), o_inst[i], NOP);
    end

    for (int i = 0; i < 16; i++) step(0, 0, 32'h0, 1, 32'(4 * i), pre(i));
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 32'h0, 1, 32'h8000_0000 + 32'(4 * i), 32'h8000_0000 | 32'(i));
    end

    for (int t = 0; t < 12; t++) begin
      step(tbl[t].rst, tbl[t].req, tbl[t].addr,
           tbl[t].we, tbl[t].laddr, tbl[t].ldata);
      chk($sformatf("tbl%0d_valid", t), 32'(o_valid[0]), 32'(tbl[t].ev));
      chk($sformatf("tbl%0d_err", t), 32'(o_err[0]), 32'(tbl[t].ee));
      chk($sformatf("tbl%0d_inst", t), o_inst[0], tbl[t].ei);
      chk($sformatf("tbl%0d_lerr", t), 32'(o_lerr[0]), 32'(tbl[t].el));
    end

    idle(4);
    bw = '{32'h0050_0093, 32'h0010_0113, 32'h1000_0002,
           32'hBBBB_BBBB, 32'h1000_0004};
    for (int s = 0; s < 9; s++) begin
      if (s < 5) step(0, 1, 32'(4 * s), 0, 32'h0, 32'h0);
      else idle(1);
      if (s >= 2 && s <= 6) begin
        chk($sformatf("burst%0d_valid", s), 32'(o_valid[1]), 32'd1);
        chk($sformatf("burst%0d_inst", s), o_inst[1], bw[s-2]);
      end else begin
        chk($sformatf("burst%0d_valid", s), 32'(o_valid[1]), 32'd0);
      end
    end

    idle(4);
    cnt = 0;
    step(0, 1, 32'h8000_0000, 0, 32'h0, 32'h0);
    cnt += int'(o_valid[1]) + int'(o_valid[2]);
    step(1, 1, 32'h8000_0004, 0, 32'h0, 32'h0);
    cnt += int'(o_valid[1]) + int'(o_valid[2]);
    chk("rstmid_inst_u2", o_inst[2], NOP);
    chk("rstmid_err_u2", 32'(o_err[2]), 32'd0);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      cnt += int'(o_valid[1]) + int'(o_valid[2]);
    end
    chk("rst_no_valid", 32'(cnt), 32'd0);
    step(0, 1, 32'h0000_0000, 0, 32'h0, 32'h0);
    chk("post_rst_u0", o_inst[0], 32'h0050_0093);
    step(0, 1, 32'h8000_0004, 0, 32'h0, 32'h0);
    step(0, 1, 32'h7FFF_FFFC, 0, 32'h0, 32'h0);
    chk("base_word1_u2", o_inst[2], 32'h8000_0001);
    chk("base_word1_err_u2", 32'(o_err[2]), 32'd0);
    idle(1);
    chk("base_below_u2", o_inst[2], NOP);
    chk("base_below_err_u2", 32'(o_err[2]), 32'd1);

    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 39) == 0,
           $urandom_range(0, 9) < 7, rand_addr(),
           $urandom_range(0, 9) < 3, rand_addr(), $urandom);
    end
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
